// File: rtl/updown_bounded_counter_if.sv
// Control, bound and status signals of the bounded up/down counter.
interface updown_bounded_counter_if #(
  parameter int unsigned BITS      = 8,
  parameter int unsigned STEP_BITS = 4
);
  logic                 enable;
  logic                 clear;
  logic                 load;
  logic                 up;
  logic                 sat_mode;
  logic [BITS-1:0]      D;
  logic [BITS-1:0]      lo;
  logic [BITS-1:0]      hi;
  logic [STEP_BITS-1:0] step;
  logic [BITS-1:0]      Q;
  logic                 tc;
  logic                 at_lo;
  logic                 at_hi;
  logic                 cfg_err;

  modport master (
    output enable, clear, load, up, sat_mode, D, lo, hi, step,
    input  Q, tc, at_lo, at_hi, cfg_err
  );

  modport slave (
    input  enable, clear, load, up, sat_mode, D, lo, hi, step,
    output Q, tc, at_lo, at_hi, cfg_err
  );
endinterface

// File: rtl/updown_bounded_counter.sv
// Up/down counter with runtime bounds [lo, hi], variable step, wrap or saturate
// at the bounds, terminal-count pulse and bound/configuration flags.
module updown_bounded_counter #(
  parameter int unsigned BITS      = 8,
  parameter int unsigned STEP_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  updown_bounded_counter_if.slave bus
);

  logic [BITS-1:0] q_q, q_d;
  logic            tc_q, tc_d;
  logic            cfg_err;
  logic [BITS:0]   step_w;
  logic [BITS:0]   sum;
  logic [BITS:0]   diff;
  logic [BITS:0]   lo_plus_step;

  function automatic logic [BITS-1:0] clamp(input logic [BITS-1:0] v,
                                            input logic [BITS-1:0] l,
                                            input logic [BITS-1:0] h);
    logic [BITS-1:0] r;
    r = v;
    if (v < l) r = l;
    else if (v > h) r = h;
    return r;
  endfunction

  assign cfg_err = bus.lo > bus.hi;

  // Next count and terminal-count: clear > hold > cfg hold > load > count.
  always_comb begin
    q_d          = q_q;
    tc_d         = 1'b0;
    // One extra bit so overshoot past either bound is seen without wraparound.
    step_w       = {{(BITS + 1 - STEP_BITS){1'b0}}, bus.step};
    sum          = {1'b0, q_q} + step_w;
    diff         = {1'b0, q_q} - step_w;
    lo_plus_step = {1'b0, bus.lo} + step_w;
    if (bus.clear) begin
      q_d = bus.lo;
    end else if (!bus.enable || cfg_err) begin
      q_d = q_q;
    end else if (bus.load) begin
      q_d = clamp(bus.D, bus.lo, bus.hi);
    end else if (q_q < bus.lo || q_q > bus.hi) begin
      // Out of range after a bound change or reset: snap back, no step this cycle.
      q_d = clamp(q_q, bus.lo, bus.hi);
    end else if (bus.step == '0) begin
      q_d = q_q;
    end else if (bus.up) begin
      if (sum <= {1'b0, bus.hi}) begin
        q_d = sum[BITS-1:0];
      end else begin
        tc_d = 1'b1;
        q_d  = bus.sat_mode ? bus.hi : bus.lo;
      end
    end else begin
      if ({1'b0, q_q} < lo_plus_step) begin
        tc_d = 1'b1;
        q_d  = bus.sat_mode ? bus.lo : bus.hi;
      end else begin
        q_d = diff[BITS-1:0];
      end
    end
  end

  // Count and terminal-count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q  <= '0;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  assign bus.Q       = q_q;
  assign bus.tc      = tc_q;
  assign bus.at_lo   = (q_q == bus.lo);
  assign bus.at_hi   = (q_q == bus.hi);
  assign bus.cfg_err = cfg_err;

endmodule
